// File: rtl/sakebi_rmii_rx_ctrl.sv
// sakebi_rmii_rx_ctrl: RMII receive frame controller feeding an async FIFO with {err,last,byte} words.
// Ports: i_rmii_REF_CLK/i_axis_ARESETn clock and async active-low reset; i_rx_enable gates new frames;
// i_max_len oversize limit; i_cnt_clr clears statistics; i_byte_valid/i_byte_data/i_frame_end/i_frame_err
// from the receiver; i_fifo_wr_ready/o_fifo_wr_en/o_fifo_wr_data FIFO write side; o_frame_done pulses
// with o_frame_status/o_frame_len; o_good_cnt/o_drop_cnt saturating frame counters.
module sakebi_rmii_rx_ctrl #(
  parameter int MIN_LEN   = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_rmii_REF_CLK,
  input  logic                 i_axis_ARESETn,
  input  logic                 i_rx_enable,
  input  logic [10:0]          i_max_len,
  input  logic                 i_cnt_clr,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte_data,
  input  logic                 i_frame_end,
  input  logic                 i_frame_err,
  input  logic                 i_fifo_wr_ready,
  output logic                 o_fifo_wr_en,
  output logic [9:0]           o_fifo_wr_data,
  output logic                 o_frame_done,
  output logic [2:0]           o_frame_status,
  output logic [10:0]          o_frame_len,
  output logic [CNT_WIDTH-1:0] o_good_cnt,
  output logic [CNT_WIDTH-1:0] o_drop_cnt
);
  typedef enum logic [1:0] {IDLE, RECV, DISCARD, DONE} state_t;
  localparam logic [2:0] ST_OK = 3'd0, ST_RUNT = 3'd1, ST_OVERSIZE = 3'd2,
                         ST_OVERFLOW = 3'd3, ST_PHY_ERR = 3'd4, ST_DISABLED = 3'd5;
  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  state_t state, state_n;
  logic [7:0] hold, hold_n;
  logic hold_v, hold_v_n;
  logic [10:0] len, len_n;
  logic [2:0] status, status_n;
  logic end_pend, end_pend_n;
  logic wr_en_n;
  logic [9:0] wr_data_n;
  logic runt;
  assign runt = len < MIN_L;
  always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn)
    if (!i_axis_ARESETn) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n    = state;
    hold_n     = hold;
    hold_v_n   = hold_v;
    len_n      = len;
    status_n   = status;
    end_pend_n = end_pend;
    wr_en_n    = 1'b0;
    wr_data_n  = o_fifo_wr_data;
    unique case (state)
      IDLE:
        if (i_byte_valid) begin
          // a frame_end arriving with the first byte is remembered and handled in the next state
          end_pend_n = i_frame_end;
          hold_n     = i_byte_data;
          hold_v_n   = i_rx_enable;
          len_n      = i_rx_enable ? 11'd1 : 11'd0;
          status_n   = i_rx_enable ? ST_OK : ST_DISABLED;
          state_n    = i_rx_enable ? RECV : DISCARD;
        end else if (i_frame_err) begin
          hold_v_n = 1'b0;
          len_n    = 11'd0;
          status_n = ST_PHY_ERR;
          state_n  = DONE;
        end
      RECV:
        if (i_byte_valid) begin
          end_pend_n = end_pend | i_frame_end;
          if (len >= i_max_len) begin
            status_n = ST_OVERSIZE;
            state_n  = DISCARD;
          end else if (!i_fifo_wr_ready) begin
            status_n = ST_OVERFLOW;
            state_n  = DISCARD;
          end else begin
            wr_en_n   = 1'b1;
            wr_data_n = {2'b00, hold};
            hold_n    = i_byte_data;
            len_n     = len + 11'd1;
          end
        end else if (i_frame_err) begin
          end_pend_n = end_pend | i_frame_end;
          status_n   = ST_PHY_ERR;
          state_n    = DISCARD;
        end else if (i_frame_end || end_pend) begin
          // the closing write is retried every cycle until the FIFO has room
          end_pend_n = !i_fifo_wr_ready;
          if (i_fifo_wr_ready) begin
            wr_en_n   = 1'b1;
            wr_data_n = {runt, 1'b1, hold};
            hold_v_n  = 1'b0;
            status_n  = runt ? ST_RUNT : ST_OK;
            state_n   = DONE;
          end
        end
      DISCARD: begin
        end_pend_n = end_pend | i_frame_end;
        if (hold_v && i_fifo_wr_ready) begin
          wr_en_n   = 1'b1;
          wr_data_n = {2'b11, hold};
          hold_v_n  = 1'b0;
        end
        if ((end_pend || i_frame_end) && (!hold_v || i_fifo_wr_ready)) begin
          end_pend_n = 1'b0;
          state_n    = DONE;
        end
      end
      DONE: begin
        end_pend_n = 1'b0;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn)
    if (!i_axis_ARESETn) begin
      hold           <= '0;
      hold_v         <= 1'b0;
      len            <= '0;
      status         <= '0;
      end_pend       <= 1'b0;
      o_fifo_wr_en   <= 1'b0;
      o_fifo_wr_data <= '0;
      o_frame_done   <= 1'b0;
      o_frame_status <= '0;
      o_frame_len    <= '0;
    end else begin
      hold           <= hold_n;
      hold_v         <= hold_v_n;
      len            <= len_n;
      status         <= status_n;
      end_pend       <= end_pend_n;
      o_fifo_wr_en   <= wr_en_n;
      o_fifo_wr_data <= wr_data_n;
      o_frame_done   <= state == DONE;
      if (state == DONE) begin
        o_frame_status <= status;
        o_frame_len    <= len;
      end
    end
  always_ff @(posedge i_rmii_REF_CLK or negedge i_axis_ARESETn)
    if (!i_axis_ARESETn) begin
      o_good_cnt <= '0;
      o_drop_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_good_cnt <= '0;
      o_drop_cnt <= '0;
    end else if (state == DONE) begin
      if (status == ST_OK && !(&o_good_cnt)) o_good_cnt <= o_good_cnt + 1'b1;
      if (status != ST_OK && !(&o_drop_cnt)) o_drop_cnt <= o_drop_cnt + 1'b1;
    end
endmodule

// File: tb/tb_sakebi_rmii_rx_ctrl.sv
// tb_sakebi_rmii_rx_ctrl: directed and randomized frames checked against a frame-level reference model.
module tb_sakebi_rmii_rx_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_enable = 1'b1;
  logic [10:0] max_len = 11'd1500;
  logic cnt_clr = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = '0;
  logic frame_end = 1'b0;
  logic frame_err = 1'b0;
  logic wr_ready = 1'b1;
  logic wr_en;
  logic [9:0] wr_data;
  logic frame_done;
  logic [2:0] frame_status;
  logic [10:0] frame_len;
  logic [3:0] good_cnt, drop_cnt;
  always #5 clk = ~clk;
  sakebi_rmii_rx_ctrl #(.MIN_LEN(64), .CNT_WIDTH(4)) dut (
    .i_rmii_REF_CLK(clk), .i_axis_ARESETn(rst_n), .i_rx_enable(rx_enable), .i_max_len(max_len),
    .i_cnt_clr(cnt_clr), .i_byte_valid(byte_valid), .i_byte_data(byte_data), .i_frame_end(frame_end),
    .i_frame_err(frame_err), .i_fifo_wr_ready(wr_ready), .o_fifo_wr_en(wr_en), .o_fifo_wr_data(wr_data),
    .o_frame_done(frame_done), .o_frame_status(frame_status), .o_frame_len(frame_len),
    .o_good_cnt(good_cnt), .o_drop_cnt(drop_cnt)
  );
  int total = 0, bad = 0;
  int exp_good = 0, exp_drop = 0;
  int stall_left = 0;
  logic [9:0] got_q[$];
  logic done_seen = 1'b0;
  logic [2:0] got_st;
  logic [10:0] got_len;
  logic prev_ready = 1'b1;
  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back(wr_data);
      total++;
      assert (prev_ready === 1'b1) else begin
        bad++;
        $error("FAIL ready_gap: write after ready=%b, required ready=1", prev_ready);
      end
    end
    if (frame_done) begin
      done_seen = 1'b1;
      got_st = frame_status;
      got_len = frame_len;
    end
    prev_ready = wr_ready;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    wr_ready = (stall_left == 0);
    @(posedge clk);
    #1;
    if (stall_left > 0) stall_left--;
  endtask
  task automatic wait_done;
    for (int c = 0; c < 80 && !done_seen; c++) cyc;
    chk("done_seen", done_seen, 1);
  endtask
  task automatic count(input logic [2:0] st, input bit clr);
    if (clr) begin
      exp_good = 0;
      exp_drop = 0;
    end else if (st == 3'd0) exp_good = exp_good < 15 ? exp_good + 1 : 15;
    else exp_drop = exp_drop < 15 ? exp_drop + 1 : 15;
    chk("good_cnt", good_cnt, exp_good);
    chk("drop_cnt", drop_cnt, exp_drop);
  endtask
  // n bytes; en=0 starts the frame disabled; k>=2 drops FIFO ready for 10 cycles from byte k;
  // coinc puts frame_end on the last byte; phy pulses frame_err after the last byte;
  // estall drops FIFO ready around frame_end; clr pulses cnt_clr as the frame closes
  task automatic send_frame(input int n, input bit en, input int k, input bit coinc, input bit phy,
                            input bit estall, input bit clr);
    logic [7:0] b[$];
    int m;
    bit trunc, errl;
    logic [2:0] st;
    got_q.delete();
    done_seen = 1'b0;
    rx_enable = en;
    for (int i = 1; i <= n; i++) begin
      byte_data = 8'($urandom);
      b.push_back(byte_data);
      byte_valid = 1'b1;
      if (i == k) stall_left = 10;
      if (i == n && coinc && !phy) frame_end = 1'b1;
      cyc;
      byte_valid = 1'b0;
      frame_end = 1'b0;
      rx_enable = 1'b1;
      if (i < n) repeat ($urandom_range(0, 2)) cyc;
    end
    if (phy) begin
      frame_err = 1'b1;
      cyc;
      frame_err = 1'b0;
    end
    if (!coinc || phy) begin
      frame_end = 1'b1;
      if (estall) stall_left = 6;
      cyc;
      frame_end = 1'b0;
    end
    if (clr) begin
      cnt_clr = 1'b1;
      cyc;
      cnt_clr = 1'b0;
    end
    wait_done;
    m = n;
    if (k >= 2 && k <= n && k - 1 < m) m = k - 1;
    if (int'(max_len) < m) m = int'(max_len);
    trunc = m < n;
    st = !en ? 3'd5 : trunc ? (m >= int'(max_len) ? 3'd2 : 3'd3) : phy ? 3'd4 : (m < 64 ? 3'd1 : 3'd0);
    errl = trunc || phy || m < 64;
    if (!en) m = 0;
    chk("wr_count", got_q.size(), m);
    for (int j = 0; j < m && j < got_q.size(); j++)
      chk($sformatf("wr_word%0d", j), got_q[j], (j == m - 1) ? {errl, 1'b1, b[j]} : {2'b00, b[j]});
    chk("status", got_st, st);
    chk("len", got_len, m);
    count(st, clr);
  endtask
  initial begin
    repeat (3) cyc;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_status", frame_status, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_good", good_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    cyc;
    send_frame(70, 1, 0, 0, 0, 0, 0);
    send_frame(20, 1, 0, 0, 0, 0, 0);
    max_len = 11'd100;
    send_frame(150, 1, 0, 0, 0, 0, 0);
    max_len = 11'd1500;
    send_frame(70, 1, 30, 0, 0, 0, 0);
    send_frame(30, 0, 0, 0, 0, 0, 0);
    send_frame(70, 1, 0, 0, 0, 0, 0);
    send_frame(10, 1, 0, 0, 1, 0, 0);
    send_frame(65, 1, 0, 1, 0, 0, 0);
    send_frame(1, 1, 0, 1, 0, 0, 0);
    send_frame(66, 1, 0, 0, 0, 1, 0);
    got_q.delete();
    done_seen = 1'b0;
    frame_err = 1'b1;
    cyc;
    frame_err = 1'b0;
    wait_done;
    chk("idle_err_writes", got_q.size(), 0);
    chk("idle_err_status", got_st, 4);
    chk("idle_err_len", got_len, 0);
    count(3'd4, 0);
    for (int r = 0; r < 14; r++) begin
      int n, k;
      n = $urandom_range(1, 140);
      k = (n >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(2, n) : 0;
      max_len = 11'($urandom_range(20, 130));
      send_frame(n, $urandom_range(0, 4) != 0, k, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0, k == 0 && $urandom_range(0, 1) == 1, 0);
    end
    max_len = 11'd1500;
    for (int r = 0; r < 16; r++) send_frame(3, 1, 0, 0, 0, 0, 0);
    for (int r = 0; r < 16; r++) send_frame(64, 1, 0, 0, 0, 0, 0);
    chk("sat_good", good_cnt, 15);
    chk("sat_drop", drop_cnt, 15);
    send_frame(64, 1, 0, 0, 0, 0, 1);
    send_frame(70, 1, 0, 0, 0, 0, 0);
    got_q.delete();
    for (int i = 1; i <= 10; i++) begin
      byte_data = 8'($urandom);
      byte_valid = 1'b1;
      cyc;
      byte_valid = 1'b0;
    end
    #2 rst_n = 1'b0;
    cyc;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_good", good_cnt, 0);
    chk("midrst_status", frame_status, 0);
    foreach (got_q[j]) chk("midrst_no_last", got_q[j][8], 0);
    cyc;
    rst_n = 1'b1;
    repeat (2) cyc;
    chk("midrst_idle_wr", wr_en, 0);
    exp_good = 0;
    exp_drop = 0;
    send_frame(64, 1, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
